// File: rtl/sigcapture_pkg.sv
// Shared types for the triggered capture buffer.
package sigcapture_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } capture_state_t;

endpackage

// File: rtl/sigcapture_if.sv
// Sample-stream, control and readout bundle for sigcapture.
interface sigcapture_if
  import sigcapture_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
);
  // en is a one-way strobe with no ready: din and force_trig are only
  // meaningful while en=1, and the capture block accepts every strobed sample.
  logic                     en;
  logic [DATA_WIDTH-1:0]    din;
  logic                     arm;
  logic                     force_trig;
  logic [DATA_WIDTH-1:0]    trig_level;
  logic [ADDRESS_WIDTH-1:0] rd_index;
  logic [DATA_WIDTH-1:0]    dout;
  logic                     busy;
  logic                     done;
  capture_state_t           state;

  modport master (
    output en, din, arm, force_trig, trig_level, rd_index,
    input  dout, busy, done, state
  );

  modport slave (
    input  en, din, arm, force_trig, trig_level, rd_index,
    output dout, busy, done, state
  );
endinterface

// File: rtl/sigcapture_ram2port.sv
// Simple dual-port RAM: one write port, one registered read port,
// read-before-write on address collision.
module ram2port #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [ADDRESS_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [ADDRESS_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_o <= '0;
    end else begin
      rdata_o <= mem_q[raddr_i];
    end
  end
endmodule

// File: rtl/sigcapture.sv
// Triggered capture buffer: keeps PRETRIG samples of history, freezes a
// DEPTH-sample window around a rising threshold crossing, reads it back by index.
module sigcapture
  import sigcapture_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int PRETRIG       = 64
) (
  input  logic        clk,
  input  logic        rst,
  sigcapture_if.slave bus
);
  localparam int                       DEPTH       = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] PRE_C       = ADDRESS_WIDTH'(PRETRIG);
  localparam logic [ADDRESS_WIDTH-1:0] POST_RELOAD = ADDRESS_WIDTH'(DEPTH - PRETRIG - 1);
  localparam bit                       NO_POST     = (DEPTH - PRETRIG) == 1;

  capture_state_t           state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] start_ptr_q, start_ptr_d;
  logic [DATA_WIDTH-1:0]    prev_q, prev_d;
  logic                     prev_valid_q, prev_valid_d;
  logic                     we;
  logic                     trig;
  logic [ADDRESS_WIDTH-1:0] rd_addr;

  assign trig = bus.force_trig |
                (prev_valid_q & (prev_q < bus.trig_level) & (bus.din >= bus.trig_level));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      start_ptr_q  <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      start_ptr_q  <= start_ptr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    start_ptr_d  = start_ptr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    we           = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.arm) begin
          state_d      = FILL;
          cnt_d        = '0;
          prev_valid_d = 1'b0;
        end
      end
      FILL: begin
        if (bus.en) begin
          we           = 1'b1;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          cnt_d        = cnt_q + 1'b1;
          prev_d       = bus.din;
          prev_valid_d = 1'b1;
          if (cnt_d == PRE_C) state_d = ARMED;
        end
      end
      ARMED: begin
        if (bus.en) begin
          we           = 1'b1;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          prev_d       = bus.din;
          prev_valid_d = 1'b1;
          // The trigger sample lands at wr_ptr_q, so the window opens PRETRIG earlier.
          if (trig) begin
            start_ptr_d = wr_ptr_q - PRE_C;
            cnt_d       = POST_RELOAD;
            state_d     = NO_POST ? DONE : POST;
          end
        end
      end
      POST: begin
        if (bus.en) begin
          we           = 1'b1;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          prev_d       = bus.din;
          prev_valid_d = 1'b1;
          cnt_d        = cnt_q - 1'b1;
          if (cnt_d == '0) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_addr   = start_ptr_q + bus.rd_index;
  assign bus.busy  = (state_q == FILL) || (state_q == ARMED) || (state_q == POST);
  assign bus.done  = (state_q == DONE);
  assign bus.state = state_q;

  ram2port #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.din),
    .raddr_i(rd_addr),
    .rdata_o(bus.dout)
  );
endmodule
